raspi_link_if: RTL and testbench

- Fabric-side slave for the 9-bit Raspberry Pi parallel link. Sits directly downstream of the Pi pins (RASPI_11..RASPI_40) in c3demo.
- Decodes the Pi's word stream into per-endpoint byte streams for the link-test echo and the firmware loader, and serialises fabric responses back to the Pi.
- Owns endpoint select words (0x100|n), the idle/sync word 0x1ff, and read-direction word presentation.

---
 rtl/raspi_link_if_if.sv | 23 ++
 rtl/raspi_link_if.sv | 126 ++++++++++++
 tb/tb_raspi_link_if.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raspi_link_if_if.sv
// Fabric-side stream bundle for the Raspberry Pi link: RX words towards the
// fabric and TX words back towards the Pi, each with a valid/ready handshake.
interface raspi_link_if_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_ep;
  logic [7:0] rx_data;
  logic       rx_overflow;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_ep;
  logic [7:0] tx_data;

  modport master (
    input  rx_valid, rx_ep, rx_data, rx_overflow, tx_ready,
    output rx_ready, tx_valid, tx_ep, tx_data
  );

  modport slave (
    output rx_valid, rx_ep, rx_data, rx_overflow, tx_ready,
    input  rx_ready, tx_valid, tx_ep, tx_data
  );
endinterface

// File: rtl/raspi_link_if.sv
// Fabric-side slave for the 9-bit Raspberry Pi parallel link: decodes Pi words
// into per-endpoint RX bytes and serialises fabric TX bytes back to the Pi.
module raspi_link_if #(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [8:0]           raspi_dat_i,
  output logic [8:0]           raspi_dat_o,
  output logic                 raspi_dat_oe,
  input  logic                 raspi_dir,
  input  logic                 raspi_clk,
  raspi_link_if_if.slave       fab
);
  localparam int unsigned RXA = $clog2(RX_DEPTH);
  localparam int unsigned TXA = $clog2(TX_DEPTH);

  logic clk_s1, clk_s2, clk_s3;
  logic dir_s1, dir_s2, dir_s3;
  logic strobe, wr_evt, rd_evt, dir_fall, rd_pending;

  // Strobe flops reset high so a strobe already high at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {clk_s1, clk_s2, clk_s3} <= '1;
      {dir_s1, dir_s2, dir_s3} <= '1;
    end else begin
      clk_s1 <= raspi_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dir_s1 <= raspi_dir;
      dir_s2 <= dir_s1;
      dir_s3 <= dir_s2;
    end
  end

  assign strobe   = clk_s2 && !clk_s3 && (dir_s2 == dir_s3);
  assign wr_evt   = strobe && dir_s2;
  assign rd_evt   = strobe && !dir_s2;
  assign dir_fall = dir_s3 && !dir_s2;

  // RX path
  logic [15:0]  rx_mem [RX_DEPTH];
  logic [RXA:0] rx_wp, rx_rp;
  logic [7:0]   cur_rx_ep;
  logic         rx_empty, rx_full, rx_pop, rx_data_word, rx_push, rx_ovf;

  assign rx_empty     = (rx_wp == rx_rp);
  assign rx_full      = (rx_wp[RXA] != rx_rp[RXA]) && (rx_wp[RXA-1:0] == rx_rp[RXA-1:0]);
  assign rx_pop       = !rx_empty && fab.rx_ready;
  assign rx_data_word = wr_evt && !raspi_dat_i[8];
  assign rx_push      = rx_data_word && (!rx_full || rx_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_ovf    <= 1'b0;
      cur_rx_ep <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_data_word && !rx_push) rx_ovf <= 1'b1;
      if (wr_evt && raspi_dat_i[8] && (raspi_dat_i != 9'h1ff))
        cur_rx_ep <= raspi_dat_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RXA-1:0]] <= {cur_rx_ep, raspi_dat_i[7:0]};
  end

  assign fab.rx_valid            = !rx_empty;
  assign {fab.rx_ep, fab.rx_data} = rx_mem[rx_rp[RXA-1:0]];
  assign fab.rx_overflow         = rx_ovf;

  // TX path
  logic [15:0]  tx_mem [TX_DEPTH];
  logic [TXA:0] tx_wp, tx_rp;
  logic [7:0]   cur_tx_ep;
  logic [15:0]  tx_head;
  logic         tx_empty, tx_full, tx_push, tx_pop, tx_sel;
  logic [8:0]   next_word;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TXA] != tx_rp[TXA]) && (tx_wp[TXA-1:0] == tx_rp[TXA-1:0]);
  assign tx_push  = fab.tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rp[TXA-1:0]];
  assign tx_pop   = rd_evt && !raspi_dat_o[8] && !tx_empty;
  assign tx_sel   = rd_evt && raspi_dat_o[8] && (raspi_dat_o != 9'h1ff);
  assign fab.tx_ready = !tx_full;

  always_comb begin
    next_word = 9'h1ff;
    if (!tx_empty) begin
      if (tx_head[15:8] != cur_tx_ep) next_word = {1'b1, tx_head[15:8]};
      else                            next_word = {1'b0, tx_head[7:0]};
    end
  end

  // The presented word is only refreshed right after a consume or at the
  // write-to-read turnaround, so it never moves under the Pi's setup window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      cur_tx_ep   <= '0;
      rd_pending  <= 1'b0;
      raspi_dat_o <= 9'h1ff;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_sel)  cur_tx_ep <= raspi_dat_o[7:0];
      rd_pending <= rd_evt;
      if (rd_pending || dir_fall) raspi_dat_o <= next_word;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TXA-1:0]] <= {fab.tx_ep, fab.tx_data};
  end

  assign raspi_dat_oe = !dir_s2;
endmodule

// File: tb/tb_raspi_link_if.sv
// Randomised bench for raspi_link_if: a queue-based model of the Pi link
// protocol predicts RX words and Pi read words; a monitor scores RX output.
module tb_raspi_link_if;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] dat_i, dat_o;
  logic       oe, dir, pclk;

  raspi_link_if_if link();

  raspi_link_if #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .raspi_dat_i  (dat_i),
    .raspi_dat_o  (dat_o),
    .raspi_dat_oe (oe),
    .raspi_dir    (dir),
    .raspi_clk    (pclk),
    .fab          (link)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rx_seen = 0;

  // Reference model: pending RX words, pending TX words, endpoint context.
  logic [15:0] exp_rx[$];
  logic [15:0] txq[$];
  logic [7:0]  m_rx_ep = 8'h00;
  logic [7:0]  m_tx_ep = 8'h00;
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && link.rx_valid === 1'b1 && link.rx_ready === 1'b1) begin
      rx_seen++;
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_extra: got %h expected none", {link.rx_ep, link.rx_data});
      end else begin
        check("rx_word", {link.rx_ep, link.rx_data}, exp_rx.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pi_strobe();
    pclk = 1'b1;
    cyc(4);
    pclk = 1'b0;
    cyc(4);
  endtask

  function automatic void model_write(input logic [8:0] w);
    if (w == 9'h1ff) return;
    if (w[8]) m_rx_ep = w[7:0];
    else if (!link.rx_ready && exp_rx.size() >= 4) m_ovf = 1'b1;
    else exp_rx.push_back({m_rx_ep, w[7:0]});
  endfunction

  function automatic logic [8:0] model_read();
    logic [15:0] head;
    if (txq.size() == 0) return 9'h1ff;
    head = txq[0];
    if (head[15:8] != m_tx_ep) begin
      m_tx_ep = head[15:8];
      return {1'b1, head[15:8]};
    end
    void'(txq.pop_front());
    return {1'b0, head[7:0]};
  endfunction

  task automatic pi_write(input logic [8:0] w);
    dat_i = w;
    model_write(w);
    pi_strobe();
  endtask

  task automatic pi_read(output logic [8:0] got);
    check("oe_read", 16'(oe), 16'd1);
    got = dat_o;
    pi_strobe();
  endtask

  task automatic read_check(input string name);
    logic [8:0] got, exp;
    exp = model_read();
    pi_read(got);
    check(name, 16'(got), 16'(exp));
  endtask

  task automatic set_dir(input logic d);
    dir = d;
    cyc(6);
  endtask

  task automatic fab_push(input logic [7:0] ep, input logic [7:0] d);
    int k = 0;
    link.tx_valid = 1'b1;
    link.tx_ep    = ep;
    link.tx_data  = d;
    while (!link.tx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_ready_timeout: got 0 expected 1");
    end else begin
      @(posedge clk);
      txq.push_back({ep, d});
    end
    #1;
    link.tx_valid = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    int k = 0;
    while (exp_rx.size() != 0 && k < 100) begin
      cyc(1);
      k++;
    end
    check(name, 16'(exp_rx.size()), 16'd0);
  endtask

  initial begin
    logic [8:0] got;
    int unsigned s0, k;

    dir = 1'b1; pclk = 1'b0; dat_i = '0;
    link.rx_ready = 1'b0; link.tx_valid = 1'b0; link.tx_ep = '0; link.tx_data = '0;
    cyc(3);
    check("rst_dat_o", 16'(dat_o), 16'h1ff);
    check("rst_oe", 16'(oe), 16'd0);
    check("rst_rx_valid", 16'(link.rx_valid), 16'd0);
    check("rst_rx_ovf", 16'(link.rx_overflow), 16'd0);
    check("rst_tx_ready", 16'(link.tx_ready), 16'd1);
    resetn = 1'b1;
    cyc(2);

    // Turnaround to read, idle reads
    link.rx_ready = 1'b1;
    dir = 1'b0;
    k = 0;
    while (!oe && k < 10) begin
      cyc(1);
      k++;
    end
    check("oe_rise_latency", 16'(k >= 2 && k <= 4), 16'd1);
    cyc(4);
    repeat (4) read_check("idle_read");

    // Sync flood then 64 data words on endpoint 0
    set_dir(1'b1);
    s0 = rx_seen;
    repeat (32) pi_write(9'h1ff);
    pi_write(9'h100);
    for (int i = 8'h40; i <= 8'h7f; i++) pi_write(9'(i));
    drain_wait("stream_drain");
    check("stream_count", 16'(rx_seen - s0), 16'd64);
    check("stream_ovf", 16'(link.rx_overflow), 16'd0);

    // Fabric words read back by the Pi
    fab_push(8'h00, 8'h27);
    fab_push(8'h00, 8'h48);
    fab_push(8'h01, 8'h05);
    set_dir(1'b0);
    repeat (6) read_check("tx_seq");

    // Word pushed during setup window must not disturb the presented word
    fab_push(8'($urandom_range(0, 3)), 8'($urandom));
    cyc(5);
    check("setup_hold", 16'(dat_o), 16'h1ff);
    pi_read(got);
    check("setup_hold_read", 16'(got), 16'h1ff);
    repeat (3) read_check("post_hold");

    // RX overflow with fabric stalled
    set_dir(1'b1);
    link.rx_ready = 1'b0;
    s0 = rx_seen;
    pi_write(9'h101);
    for (int i = 0; i < 6; i++) pi_write(9'(i));
    check("ovf_set", 16'(link.rx_overflow), 16'(m_ovf));
    check("ovf_valid", 16'(link.rx_valid), 16'd1);
    link.rx_ready = 1'b1;
    drain_wait("ovf_drain");
    cyc(5);
    check("ovf_count", 16'(rx_seen - s0), 16'd4);
    check("ovf_sticky", 16'(link.rx_overflow), 16'd1);

    // Reset between a strobe and its detection
    pi_write(9'h105);
    drain_wait("pre_reset_drain");
    dat_i = 9'h077;
    pclk = 1'b1;
    cyc(1);
    resetn = 1'b0;
    m_rx_ep = 8'h00; m_tx_ep = 8'h00; m_ovf = 1'b0;
    txq.delete();
    #1;
    check("async_rst_valid", 16'(link.rx_valid), 16'd0);
    cyc(2);
    pclk = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    check("post_rst_ovf", 16'(link.rx_overflow), 16'd0);
    check("post_rst_dat_o", 16'(dat_o), 16'h1ff);
    check("post_rst_valid", 16'(link.rx_valid), 16'd0);
    pi_write(9'h033);
    drain_wait("post_rst_drain");

    // Randomised rounds: fabric fills TX, Pi writes, then Pi drains TX
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 4);
      for (int j = 0; j < int'(k); j++) fab_push(8'($urandom_range(0, 3)), 8'($urandom));
      check("tx_ready_level", 16'(link.tx_ready), 16'(txq.size() < 4));
      repeat ($urandom_range(1, 8)) begin
        k = $urandom_range(0, 7);
        if (k == 0)      pi_write(9'h1ff);
        else if (k < 3)  pi_write({1'b1, 8'($urandom_range(0, 3))});
        else             pi_write({1'b0, 8'($urandom)});
      end
      drain_wait("rand_drain");
      set_dir(1'b0);
      k = 0;
      while (txq.size() != 0 && k < 12) begin
        read_check("rand_read");
        k++;
      end
      read_check("rand_idle");
      set_dir(1'b1);
    end
    check("final_ovf", 16'(link.rx_overflow), 16'(m_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
